// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin register-file writeback arbiter with per-register pending-write scoreboard
module rf_wb_arbiter #(
  parameter int NREQ = 2,
  parameter int CNTW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid,
  input  logic [4:0]      req_addr0,
  input  logic [4:0]      req_addr1,
  input  logic [31:0]     req_data0,
  input  logic [31:0]     req_data1,
  output logic [NREQ-1:0] req_ready,
  output logic            RFWE,
  output logic [4:0]      RFWA,
  output logic [31:0]     RFWD,
  input  logic            iss_valid,
  input  logic [4:0]      iss_addr,
  input  logic [4:0]      q_addr1,
  input  logic [4:0]      q_addr2,
  output logic            stall,
  output logic            sb_err
);
  logic [1:0]      r_full;
  logic [4:0]      r_addr0, r_addr1;
  logic [31:0]     r_data0, r_data1;
  logic            r_rr;
  logic [CNTW-1:0] r_cnt [0:31];
  logic            r_err;
  logic [1:0]      w_gnt, w_load;
  logic [31:0]     w_inc, w_dec;
  logic            w_err;
  // grant the only full buffer, or on a tie the one not granted last
  always_comb begin
    w_gnt[0] = r_full[0] & (!r_full[1] | r_rr);
    w_gnt[1] = r_full[1] & (!r_full[0] | !r_rr);
    req_ready = {2{!rst}} & (~r_full | w_gnt);
    w_load = req_valid & req_ready & {req_addr1 != 5'd0, req_addr0 != 5'd0};
    RFWE = |w_gnt;
    RFWA = w_gnt[0] ? r_addr0 : w_gnt[1] ? r_addr1 : 5'd0;
    RFWD = w_gnt[0] ? r_data0 : w_gnt[1] ? r_data1 : 32'd0;
    stall = (q_addr1 != 5'd0 && r_cnt[q_addr1] != '0) || (q_addr2 != 5'd0 && r_cnt[q_addr2] != '0);
    sb_err = r_err;
  end
  // one-hot issue/writeback hits and over/underflow detection per register
  always_comb begin
    w_inc = (iss_valid && iss_addr != 5'd0) ? 32'd1 << iss_addr : 32'd0;
    w_dec = RFWE ? 32'd1 << RFWA : 32'd0;
    w_err = 1'b0;
    for (int k = 0; k < 32; k++)
      w_err = w_err | (w_inc[k] & !w_dec[k] & (r_cnt[k] == '1)) | (w_dec[k] & !w_inc[k] & (r_cnt[k] == '0));
  end
  // buffer occupancy and last-grant pointer; a drained buffer may refill in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 2'b00;
      r_rr <= 1'b1;
    end else begin
      r_full <= (r_full & ~w_gnt) | w_load;
      if (RFWE) r_rr <= w_gnt[1];
    end
  end
  // buffer payload, captured only on accepted nonzero-destination writes
  always_ff @(posedge clk) begin
    if (w_load[0]) {r_addr0, r_data0} <= {req_addr0, req_data0};
    if (w_load[1]) {r_addr1, r_data1} <= {req_addr1, req_data1};
  end
  // saturating pending counters; coincident issue and writeback cancel out
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 32; k++) r_cnt[k] <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= r_err | w_err;
      for (int k = 0; k < 32; k++)
        if (w_inc[k] && !w_dec[k] && r_cnt[k] != '1) r_cnt[k] <= r_cnt[k] + CNTW'(1);
        else if (w_dec[k] && !w_inc[k] && r_cnt[k] != '0) r_cnt[k] <= r_cnt[k] - CNTW'(1);
    end
  end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed vector table plus fairness and latency sequences for rf_wb_arbiter
module tb_rf_wb_arbiter;
  logic        clk, rst;
  logic [1:0]  req_valid, req_ready;
  logic [4:0]  req_addr0, req_addr1, RFWA, iss_addr, q_addr1, q_addr2;
  logic [31:0] req_data0, req_data1, RFWD;
  logic        RFWE, iss_valid, stall, sb_err;
  int total = 0, bad = 0;

  typedef struct {
    logic        rst;
    logic [1:0]  v;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        iv;
    logic [4:0]  ia, q1, q2;
    logic [1:0]  rdy;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        st, er;
  } vec_t;
  vec_t tbl[$];

  rf_wb_arbiter #(.NREQ(2), .CNTW(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_data0(req_data0), .req_data1(req_data1),
    .req_ready(req_ready), .RFWE(RFWE), .RFWA(RFWA), .RFWD(RFWD),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .q_addr1(q_addr1), .q_addr2(q_addr2), .stall(stall), .sb_err(sb_err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                     input logic [4:0] a1, input logic [31:0] d1, input logic iv, input logic [4:0] ia,
                     input logic [4:0] q1, input logic [4:0] q2, input logic [1:0] rdy, input logic we,
                     input logic [4:0] wa, input logic [31:0] wd, input logic st, input logic er);
    vec_t t;
    t.rst = r; t.v = v; t.a0 = a0; t.d0 = d0; t.a1 = a1; t.d1 = d1; t.iv = iv; t.ia = ia;
    t.q1 = q1; t.q2 = q2; t.rdy = rdy; t.we = we; t.wa = wa; t.wd = wd; t.st = st; t.er = er;
    tbl.push_back(t);
  endtask

  task automatic chk(input string n, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h want=%0h", n, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                       input logic [4:0] a1, input logic [31:0] d1, input logic iv, input logic [4:0] ia,
                       input logic [4:0] q1, input logic [4:0] q2);
    rst = r; req_valid = v; req_addr0 = a0; req_data0 = d0; req_addr1 = a1; req_data1 = d1;
    iss_valid = iv; iss_addr = ia; q_addr1 = q1; q_addr2 = q2;
  endtask

  initial begin
    int n;
    //   rst v  a0  d0            a1  d1            iv ia  q1  q2   rdy we wa  wd            st er
    add(0, 0, 0, 0,            0, 0,            0, 0,  0,  0,   3, 0, 0, 0,            0, 0);
    add(0, 1, 5, 32'hDEADBEEF, 0, 0,            1, 5,  0,  0,   3, 0, 0, 0,            0, 0);
    add(0, 0, 0, 0,            0, 0,            0, 0,  5,  0,   3, 1, 5, 32'hDEADBEEF, 1, 0);
    add(0, 0, 0, 0,            0, 0,            0, 0,  5,  0,   3, 0, 0, 0,            0, 0);
    add(1, 0, 0, 0,            0, 0,            0, 0,  0,  0,   0, 0, 0, 0,            0, 0);
    add(0, 3, 3, 32'h11,       4, 32'h22,       0, 0,  0,  0,   3, 0, 0, 0,            0, 0);
    add(0, 3, 3, 32'h11,       4, 32'h22,       1, 3,  0,  0,   1, 1, 3, 32'h11,       0, 0);
    add(0, 3, 3, 32'h11,       4, 32'h22,       1, 4,  0,  0,   2, 1, 4, 32'h22,       0, 0);
    add(0, 3, 3, 32'h11,       4, 32'h22,       1, 3,  0,  0,   1, 1, 3, 32'h11,       0, 0);
    add(0, 3, 3, 32'h11,       4, 32'h22,       1, 4,  0,  0,   2, 1, 4, 32'h22,       0, 0);
    add(0, 0, 0, 0,            0, 0,            1, 3,  0,  0,   1, 1, 3, 32'h11,       0, 0);
    add(0, 0, 0, 0,            0, 0,            1, 4,  0,  0,   3, 1, 4, 32'h22,       0, 0);
    add(0, 0, 0, 0,            0, 0,            0, 0,  3,  4,   3, 0, 0, 0,            0, 0);
    add(0, 2, 0, 0,            0, 32'hFFFFFFFF, 0, 0,  0,  0,   3, 0, 0, 0,            0, 0);
    add(0, 0, 0, 0,            0, 0,            0, 0,  0,  0,   3, 0, 0, 0,            0, 0);
    add(0, 0, 0, 0,            0, 0,            0, 0,  0,  0,   3, 0, 0, 0,            0, 0);
    add(0, 0, 0, 0,            0, 0,            0, 0,  0,  0,   3, 0, 0, 0,            0, 0);
    add(0, 0, 0, 0,            0, 0,            1, 7,  0,  0,   3, 0, 0, 0,            0, 0);
    add(0, 1, 7, 32'h77,       0, 0,            0, 0,  7,  0,   3, 0, 0, 0,            1, 0);
    add(0, 0, 0, 0,            0, 0,            0, 0,  7,  0,   3, 1, 7, 32'h77,       1, 0);
    add(0, 0, 0, 0,            0, 0,            0, 0,  7,  0,   3, 0, 0, 0,            0, 0);
    add(0, 0, 0, 0,            0, 0,            1, 7,  0,  0,   3, 0, 0, 0,            0, 0);
    add(0, 1, 7, 32'h78,       0, 0,            0, 0,  0,  7,   3, 0, 0, 0,            1, 0);
    add(0, 0, 0, 0,            0, 0,            1, 7,  0,  7,   3, 1, 7, 32'h78,       1, 0);
    add(0, 0, 0, 0,            0, 0,            0, 0,  0,  7,   3, 0, 0, 0,            1, 0);
    add(0, 0, 0, 0,            0, 0,            1, 9,  9,  0,   3, 0, 0, 0,            0, 0);
    add(0, 0, 0, 0,            0, 0,            1, 9,  9,  0,   3, 0, 0, 0,            1, 0);
    add(0, 0, 0, 0,            0, 0,            1, 9,  9,  0,   3, 0, 0, 0,            1, 0);
    add(0, 0, 0, 0,            0, 0,            1, 9,  9,  0,   3, 0, 0, 0,            1, 0);
    add(0, 2, 0, 0,            9, 32'h99,       0, 0,  9,  0,   3, 0, 0, 0,            1, 1);
    add(0, 2, 0, 0,            9, 32'h9A,       0, 0,  9,  0,   3, 1, 9, 32'h99,       1, 1);
    add(0, 2, 0, 0,            9, 32'h9B,       0, 0,  9,  0,   3, 1, 9, 32'h9A,       1, 1);
    add(0, 0, 0, 0,            0, 0,            0, 0,  9,  0,   3, 1, 9, 32'h9B,       1, 1);
    add(0, 0, 0, 0,            0, 0,            0, 0,  9,  0,   3, 0, 0, 0,            0, 1);
    add(0, 3, 3, 32'h33,       4, 32'h44,       0, 0,  0,  0,   3, 0, 0, 0,            0, 1);
    add(1, 0, 0, 0,            0, 0,            0, 0,  0,  0,   0, 1, 3, 32'h33,       0, 1);
    add(0, 3, 5, 32'h55,       6, 32'h66,       0, 0,  9,  0,   3, 0, 0, 0,            0, 0);
    add(0, 0, 0, 0,            0, 0,            0, 0,  0,  0,   1, 1, 5, 32'h55,       0, 0);
    add(0, 0, 0, 0,            0, 0,            0, 0,  0,  0,   3, 1, 6, 32'h66,       0, 1);
    add(0, 0, 0, 0,            0, 0,            0, 0,  0,  0,   3, 0, 0, 0,            0, 1);

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].v, tbl[i].a0, tbl[i].d0, tbl[i].a1, tbl[i].d1, tbl[i].iv, tbl[i].ia, tbl[i].q1, tbl[i].q2);
      #2;
      chk("ready", i, 32'(req_ready), 32'(tbl[i].rdy));
      chk("rfwe", i, 32'(RFWE), 32'(tbl[i].we));
      chk("rfwa", i, 32'(RFWA), 32'(tbl[i].wa));
      chk("rfwd", i, RFWD, tbl[i].wd);
      chk("stall", i, 32'(stall), 32'(tbl[i].st));
      chk("sb_err", i, 32'(sb_err), 32'(tbl[i].er));
    end

    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 3, 3, 32'h11, 4, 32'h22, 0, 0, 0, 0);
    #2;
    chk("fair_idle_we", 0, 32'(RFWE), 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      iss_valid = 1;
      iss_addr = k[0] ? 5'd4 : 5'd3;
      #2;
      chk("fair_we", k, 32'(RFWE), 1);
      chk("fair_wa", k, 32'(RFWA), k[0] ? 32'd4 : 32'd3);
      chk("fair_ready", k, 32'(req_ready), k[0] ? 32'd2 : 32'd1);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("fair_err", 0, 32'(sb_err), 0);

    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 1, 12, 32'hC0FFEE, 0, 0, 1, 12, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    n = 0;
    while (!RFWE && n < 4) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("latency", 0, 32'(n), 0);
    chk("lat_wa", 0, 32'(RFWA), 12);
    chk("lat_wd", 0, RFWD, 32'hC0FFEE);
    @(negedge clk);
    #2;
    chk("lat_done_we", 0, 32'(RFWE), 0);
    chk("lat_err", 0, 32'(sb_err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Writeback arbiter and pending-write scoreboard for the 32x32 register file. It takes register writes from two independent producers, the ALU writeback (requester 0) and the load/multi-cycle unit (requester 1), and buffers one write per producer. It grants the single register-file write port round-robin. It also tracks outstanding writes per register so the issue stage can stall on read-after-write hazards.

## Interface
Parameters:
- NREQ, 2, number of write requesters (fixed at 2 in this revision)
- CNTW, 2, width of each per-register pending counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid[1:0]  in  2  requester i presents a write
- req_addr0, req_addr1  in  5 each  destination register
- req_data0, req_data1  in  32 each  write data
- req_ready[1:0]  out  2  requester i write accepted this cycle when valid&ready
- RFWE  out  1  register-file write enable
- RFWA  out  5  register-file write address
- RFWD  out  32  register-file write data
- iss_valid  in  1  issue stage dispatches an instruction that will write iss_addr
- iss_addr  in  5  destination of the issuing instruction
- q_addr1, q_addr2  in  5 each  source registers of the instruction in issue
- stall  out  1  q_addr1 or q_addr2 has a pending write
- sb_err  out  1  sticky: pending-counter overflow or underflow

## Operation
- Per requester: one holding buffer {full, addr, data}.
- req_ready[i] = !rst & (!full[i] | grant[i]). A buffer that is being drained this cycle may be refilled in the same cycle.
- On accept with addr != 0: buffer i loads addr and data, and full is set.
- On accept with addr == 0: the write is dropped. The buffer is not loaded, and the pending counter for register 0 is not touched.
- Arbiter: candidates are the full buffers. If one is full, it is granted. If both are full, the requester not granted last is granted.
- rr_ptr records the last granted index. It is updated only on a grant and resets to 1, so requester 0 wins the first tie.
- Grant outputs: RFWE=1, RFWA/RFWD are taken from the granted buffer, and that buffer's full clears at the edge unless it is refilled.
- No grant: RFWE=0, RFWA=0, RFWD=0.
- Scoreboard: each register r in 1..31 has a pending counter cnt[r] of CNTW bits. Register 0 is never pending.
  - iss_valid & iss_addr!=0 increments cnt[iss_addr].
  - RFWE decrements cnt[RFWA].
  - If both events hit the same register in the same cycle, the counter is unchanged.
  - Increment at max (3): the counter holds and sb_err is set.
  - Decrement at 0: the counter holds at 0 and sb_err is set.
  - sb_err stays set until rst.
- stall = (q_addr1!=0 & cnt[q_addr1]!=0) | (q_addr2!=0 & cnt[q_addr2]!=0), computed combinationally from registered counters.
- A write granted in cycle N clears stall from cycle N+1. Same-cycle bypass is the forwarding unit's job, not this block's.

## Timing
- Reset (rst high at an edge): both full=0, all cnt=0, rr_ptr=1, sb_err=0.
- After reset: RFWE=0, RFWA=0, RFWD=0, stall=0, sb_err=0. req_ready=0 while rst is high and 2'b11 on the first cycle after.
- Latency: accept at edge N, RFWE asserted during cycle N+1, register file written at edge N+1. Minimum is 1 cycle; a losing requester waits 1 more cycle per conflict.
- Throughput: one register-file write per cycle total. Each requester can sustain one write per cycle when uncontested, via drain+refill.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1,…
- All outputs except req_ready, RFWE/RFWA/RFWD and stall are registered. Those five are combinational from registered state, plus rst for req_ready.
- Reset mid-operation discards buffered writes: RFWE is 0 in the cycle after rst.

## Test plan
- **Single write:** req_valid0=1, addr 5, data 0xDEADBEEF for one cycle. Next cycle RFWE=1, RFWA=5, RFWD=0xDEADBEEF. Following cycle RFWE=0.
- **Contention:** both requesters hold valid continuously (addr 3 / 0x11, addr 4 / 0x22). After reset, grants go 0,1,0,1. req_ready toggles so that each requester is accepted every other cycle, and neither is ever starved.
- **$0 drop:** req_valid1=1, addr 0, data 0xFFFFFFFF. req_ready1=1, RFWE stays 0 for the next 3 cycles, and cnt/stall are unaffected.
- **Scoreboard:**
  - iss_valid with iss_addr=7, then q_addr1=7: stall=1.
  - Requester 0 writes addr 7; in the cycle after RFWE, stall=0.
  - Issue addr 7 and RFWE to addr 7 in the same cycle: counter unchanged.
- **Overflow:** four iss_valid to addr 9 with no write gives sb_err=1 and cnt[9]=3. Three writes to 9 then give stall=0 for q_addr1=9. sb_err stays 1 until rst.
- **Reset mid-flight:** both buffers full, then rst asserted for 1 cycle. Next cycle RFWE=0, stall=0, req_ready=2'b11, and the first tie goes to requester 0.
